// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and sample type.
// Used by the frame collector, scrambler and butterfly stages.
package fft_pkg;

    localparam int FFT_SAMPLES = 8;
    localparam int FFT_WIDTH   = 16;

    typedef logic [FFT_WIDTH-1:0] fft_sample_t;

    // Bit-reverse the low 'bits' bits of idx (scrambler ordering).
    function automatic int unsigned fft_bitrev(
        input int unsigned idx,
        input int unsigned bits
    );
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < bits; b++) begin
            r = (r << 1) | ((idx >> b) & 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_collector_if.sv
// Sample-in / frame-out bundle of the FFT frame collector.
// master = producer+consumer side, slave = collector side.
interface fft_frame_collector_if
    import fft_pkg::*;
#(
    parameter int SAMPLES = FFT_SAMPLES,
    parameter int WIDTH   = FFT_WIDTH
);
    localparam int IDXW = $clog2(SAMPLES);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             frame_valid;
    logic             frame_ready;
    logic [WIDTH-1:0] frame_out [SAMPLES];
    logic [IDXW-1:0]  fill_idx;

    modport master (
        output in_valid, in_data, flush, frame_ready,
        input  in_ready, frame_valid, frame_out, fill_idx
    );

    modport slave (
        input  in_valid, in_data, flush, frame_ready,
        output in_ready, frame_valid, frame_out, fill_idx
    );

endinterface

// File: rtl/fft_frame_bank.sv
// One SAMPLES x WIDTH frame register bank.
// Ports: clk, we_i/idx_i/data_i indexed write, data_o full parallel read.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int SAMPLES = FFT_SAMPLES,
    parameter int WIDTH   = FFT_WIDTH,
    localparam int IDXW   = $clog2(SAMPLES)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDXW-1:0]  idx_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o [SAMPLES]
);

    // Data is never reset; bank_full in the top qualifies it.
    logic [WIDTH-1:0] mem_q [SAMPLES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= data_i;
        end
    end

    assign data_o = mem_q;

endmodule

// File: rtl/fft_frame_collector.sv
// Ping-pong streaming-to-frame buffer feeding the FFT scrambler.
// Ports: clk, rst_n (async active-low), bus (slave: samples in, frames out).
module fft_frame_collector
    import fft_pkg::*;
#(
    parameter int SAMPLES = FFT_SAMPLES,
    parameter int WIDTH   = FFT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_frame_collector_if.slave  bus
);

    localparam int IDXW = $clog2(SAMPLES);
    localparam logic [IDXW-1:0] LAST = IDXW'(SAMPLES - 1);

    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [IDXW-1:0] wr_idx_q,  wr_idx_d;
    logic [1:0]      full_q,    full_d;

    logic             accept;
    logic             release_f;
    logic [1:0]       we;
    logic [WIDTH-1:0] bank_rd [2][SAMPLES];

    assign bus.in_ready    = !full_q[wr_bank_q] && !bus.flush;
    assign bus.frame_valid = full_q[rd_bank_q];
    assign bus.fill_idx    = wr_idx_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign release_f = full_q[rd_bank_q] && bus.frame_ready;

    assign we[0] = accept && !wr_bank_q;
    assign we[1] = accept &&  wr_bank_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .SAMPLES (SAMPLES),
            .WIDTH   (WIDTH)
        ) u_bank (
            .clk    (clk),
            .we_i   (we[b]),
            .idx_i  (wr_idx_q),
            .data_i (bus.in_data),
            .data_o (bank_rd[b])
        );
    end

    always_comb begin
        for (int i = 0; i < SAMPLES; i++) begin
            bus.frame_out[i] = bank_rd[rd_bank_q][i];
        end
    end

    // Completion and release never hit the same bank: the
    // filling bank is by construction not full.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        full_d    = full_q;
        if (bus.flush) begin
            wr_idx_d = '0;
        end else if (accept) begin
            if (wr_idx_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_idx_d          = '0;
            end else begin
                wr_idx_d = wr_idx_q + IDXW'(1);
            end
        end
        if (release_f) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            full_q    <= 2'b00;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            full_q    <= full_d;
        end
    end

endmodule

// File: doc/fft_frame_collector.md
# fft_frame_collector

Streaming-to-frame buffer placed directly upstream of `scrambleForFFT`. It accepts one sample per cycle over a valid/ready handshake and packs samples into SAMPLES-deep frames using two ping-pong banks. Each completed frame is presented in parallel on `frame_out`, in natural order (index 0 = first sample received), so it connects directly to the scrambler's `input_stream`. Backpressure prevents sample loss, and continuous one-sample-per-cycle throughput is sustained whenever the consumer drains frames in time.

## Interface
- `SAMPLES`, 8: frame length; power of two, ≥ 2.
- `WIDTH`, 16: sample width in bits.
- `IDXW`, `$clog2(SAMPLES)`: derived sample-index width; not for override.

- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: collector can accept a sample this cycle.
- `in_data` in WIDTH: sample.
- `flush` in 1: discard the partially filled frame.
- `frame_valid` out 1: `frame_out` holds a complete frame.
- `frame_ready` in 1: consumer takes the frame.
- `frame_out` out [WIDTH-1:0] [SAMPLES-1:0]: unpacked frame; `frame_out[i]` is the i-th received sample.
- `fill_idx` out IDXW: number of samples already written into the filling bank.

## Operation
- **Storage:** two banks, each SAMPLES×WIDTH. State registers:
  - `wr_bank`, `rd_bank` (1 bit each)
  - `wr_idx` (IDXW)
  - `bank_full[1:0]`
- **Handshake definitions:**
  - `in_ready = !bank_full[wr_bank] && !flush`
  - Accept = `in_valid && in_ready`; on accept, write `bank[wr_bank][wr_idx] <= in_data`.
- **Write pointer on accept:**
  - If `wr_idx == SAMPLES-1`: set `bank_full[wr_bank]`, toggle `wr_bank`, set `wr_idx <= 0`.
  - Otherwise: `wr_idx++`.
- **Output:**
  - `frame_valid = bank_full[rd_bank]`
  - `frame_out = bank[rd_bank]`, taken directly from the registers.
- **Frame release:** on `frame_valid && frame_ready`, clear `bank_full[rd_bank]` and toggle `rd_bank`.
- **Flush:**
  - Sets `wr_idx <= 0`; the partial frame is abandoned.
  - Full banks and `rd_bank` are unaffected.
  - The write is suppressed because `in_ready` is 0 that cycle.
- **Simultaneous complete and release:** frame completion and frame release in the same cycle always touch different banks. The filling bank is never full, so the bank being completed is never the one being released. Both updates apply.
- **Per-bank state sequence:** EMPTY → FILLING → FULL → (released) EMPTY. The state is implied by `bank_full` and `wr_bank`; no separate FSM encoding.
- **Input data while `in_ready` = 0:** ignored.
- **Bank contents:** stale data is never cleared. Only `bank_full` qualifies it.

## Timing
- **Reset values (async on `rst_n` low):**
  - `wr_bank = 0`, `rd_bank = 0`, `wr_idx = 0`, `bank_full = 2'b00`
  - `frame_valid = 0`, `in_ready = 1` (when `flush` = 0), `fill_idx = 0`
  - Bank data is not reset; `frame_out` is X/don't-care until the first frame.
- **Latency:** last sample accepted at edge N → `frame_valid` high after edge N, i.e. usable in cycle N+1.
- **Throughput:** continuous, as long as each frame is released within SAMPLES cycles of completing.
- **Stall:** with both banks full, `in_ready` is 0. It rises in the cycle after a release edge.
- **`frame_out` stability:** `frame_out` is stable while `frame_valid` is high and `frame_ready` is low. This is required because the scrambler is combinational.
- **Reset mid-frame:** all in-flight samples and full frames are lost; the module restarts at bank 0.

## Structure
- **Package `fft_pkg`:**
  - `FFT_SAMPLES` (= 8) and `FFT_WIDTH` (= 16) constants.
  - `typedef logic [FFT_WIDTH-1:0] fft_sample_t`.
  - Both are shared with `scrambleForFFT` and downstream butterfly stages.
- **One sub-module, `fft_frame_bank`:** a SAMPLES×WIDTH register array with indexed write enable and full parallel read. It is instantiated twice; the read mux on `rd_bank` stays in the top module.

## Test plan
1. **Reset:** `rst_n` = 0 with `in_valid` = 1. Required: `in_ready` = 1, `frame_valid` = 0, `fill_idx` = 0.
2. **Single frame:** stream 0..7 with `frame_ready` = 0. Required:
   - `frame_valid` rises the cycle after the 8th accept.
   - `frame_out[i] == i`.
   - Feeding `scrambleForFFT` gives output 0,4,2,6,1,5,3,7.
3. **Full backpressure:** stream 16 samples with `frame_ready` = 0. Required:
   - `in_ready` drops after the 16th accept; the 17th sample is held.
   - Release one frame → `in_ready` = 1 next cycle.
   - Second frame = samples 8..15.
4. **Continuous throughput:** `frame_ready` = 1 and `in_valid` = 1 for 64 cycles. Required:
   - `in_ready` never falls.
   - 8 frames, each with correct contents and order.
5. **Flush:** accept 5 samples, then assert `flush` together with `in_valid`. Required:
   - That sample is not taken; `fill_idx` = 0.
   - The next 8 samples form the frame.
   - An already-full bank is delivered unchanged.
6. **Same-cycle complete and release:** bank 0 full and released in the same cycle as the 8th sample of bank 1. Required: `frame_valid` stays high, and `frame_out` switches to bank 1 data.
